// File: rtl/hex_display_driver.sv
// rtl/hex_display_driver.sv - PIO word to active-low seven-segment driver (decimal via double-dabble, or hex)
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits in decimal mode.
module hex_display_driver #(
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           value_in,
  input  logic                  hex_mode,
  output logic [7*DIGITS-1:0]   hex_seg,
  output logic                  busy,
  output logic                  valid,
  output logic                  overflow
);

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_DONE} state_t;

  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  state_t               state_q, state_d;
  logic [31:0]          shadow_val_q, shadow_val_d;
  logic                 shadow_mode_q, shadow_mode_d;
  logic                 force_q, force_d;
  logic [71:0]          sreg_q, sreg_d;
  logic [5:0]           cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;
  logic                 ovf_q, ovf_d;
  logic [7*DIGITS-1:0]  seg_q, seg_d;

  logic                 capture;
  logic [39:0]          bcd;
  logic [7*DIGITS-1:0]  disp_seg;
  logic                 disp_ovf;

  // Active-low g..a pattern for one hexadecimal digit.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
  function automatic logic [39:0] add3(input logic [39:0] b);
    logic [39:0] r;
    r = b;
    for (int i = 0; i < 10; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign capture = (value_in != shadow_val_q) || (hex_mode != shadow_mode_q) || force_q;
  assign bcd     = sreg_q[71:32];

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: hex skips the conversion, decimal always runs all 32 iterations.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (capture) state_d = hex_mode ? S_DONE : S_CONVERT;
      S_CONVERT: if (cnt_q == 6'd31) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Display image built from the captured value: decimal from the finished BCD, hex from the shadow.
  always_comb begin
    logic found;
    logic [3:0] dig;
    disp_ovf = 1'b0;
    disp_seg = '1;
    found    = 1'b0;
    dig      = 4'h0;
    if (shadow_mode_q) begin
      for (int d = DIGITS; d < 8; d++) begin
        if (shadow_val_q[4*d +: 4] != 4'h0) disp_ovf = 1'b1;
      end
    end else begin
      for (int d = DIGITS; d < 10; d++) begin
        if (bcd[4*d +: 4] != 4'h0) disp_ovf = 1'b1;
      end
    end
    for (int d = DIGITS - 1; d >= 0; d--) begin
      dig = shadow_mode_q ? shadow_val_q[4*d +: 4] : bcd[4*d +: 4];
      if (dig != 4'h0) found = 1'b1;
      if (disp_ovf) begin
        disp_seg[7*d +: 7] = SEG_DASH;
      end else begin
`ifdef LEADING_ZERO_BLANK_EN
        if (!shadow_mode_q && !found && d != 0) disp_seg[7*d +: 7] = SEG_BLANK;
        else                                    disp_seg[7*d +: 7] = seg7(dig);
`else
        disp_seg[7*d +: 7] = seg7(dig);
`endif
      end
    end
  end

  // Output/datapath next values: capture in IDLE, iterate in CONVERT, publish in DONE.
  always_comb begin
    shadow_val_d  = shadow_val_q;
    shadow_mode_d = shadow_mode_q;
    force_d       = force_q;
    sreg_d        = sreg_q;
    cnt_d         = cnt_q;
    busy_d        = busy_q;
    valid_d       = valid_q;
    ovf_d         = ovf_q;
    seg_d         = seg_q;
    case (state_q)
      S_IDLE: begin
        if (capture) begin
          shadow_val_d  = value_in;
          shadow_mode_d = hex_mode;
          force_d       = 1'b0;
          busy_d        = 1'b1;
          if (!hex_mode) begin
            sreg_d = {40'b0, value_in};
            cnt_d  = 6'd0;
          end
        end
      end
      S_CONVERT: begin
        sreg_d = {add3(sreg_q[71:32]), sreg_q[31:0]} << 1;
        cnt_d  = cnt_q + 6'd1;
      end
      S_DONE: begin
        seg_d   = disp_seg;
        ovf_d   = disp_ovf;
        valid_d = 1'b1;
        busy_d  = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath and output registers; force starts high so the current input is always shown after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_val_q  <= 32'd0;
      shadow_mode_q <= 1'b0;
      force_q       <= 1'b1;
      sreg_q        <= 72'd0;
      cnt_q         <= 6'd0;
      busy_q        <= 1'b0;
      valid_q       <= 1'b0;
      ovf_q         <= 1'b0;
      seg_q         <= '1;
    end else begin
      shadow_val_q  <= shadow_val_d;
      shadow_mode_q <= shadow_mode_d;
      force_q       <= force_d;
      sreg_q        <= sreg_d;
      cnt_q         <= cnt_d;
      busy_q        <= busy_d;
      valid_q       <= valid_d;
      ovf_q         <= ovf_d;
      seg_q         <= seg_d;
    end
  end

  assign hex_seg  = seg_q;
  assign busy     = busy_q;
  assign valid    = valid_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_hex_display_driver.sv
// tb/tb_hex_display_driver.sv - scoreboard bench for hex_display_driver (DIGITS=6)
module tb_hex_display_driver;

  localparam int DIGITS = 6;

  logic                 clk;
  logic                 reset;
  logic [31:0]          value_in;
  logic                 hex_mode;
  logic [7*DIGITS-1:0]  hex_seg;
  logic                 busy;
  logic                 valid;
  logic                 overflow;

  typedef struct {
    logic [41:0] seg;
    logic        ovf;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   push_cnt = 0;

  hex_display_driver #(.DIGITS(DIGITS)) dut (
    .clk      (clk),
    .reset    (reset),
    .value_in (value_in),
    .hex_mode (hex_mode),
    .hex_seg  (hex_seg),
    .busy     (busy),
    .valid    (valid),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [41:0] mk(input logic [6:0] d5, input logic [6:0] d4, input logic [6:0] d3,
                                     input logic [6:0] d2, input logic [6:0] d1, input logic [6:0] d0);
    return {d5, d4, d3, d2, d1, d0};
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = 7'h7F;
`else
  localparam logic [6:0] LZ = 7'h40;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push(input logic [41:0] seg, input logic ovf, input int lat);
    exp_t e;
    e.seg = seg;
    e.ovf = ovf;
    e.lat = lat;
    sb.push_back(e);
    push_cnt++;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done_cnt < push_cnt && n < 500) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (done_cnt < push_cnt) begin
      errors++;
      $display("FAIL %s_timeout actual=%0d required=%0d", name, done_cnt, push_cnt);
    end
  endtask

  task automatic wait_busy(input string name);
    int n = 0;
    while (!busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!busy) begin
      errors++;
      $display("FAIL %s_busy_timeout actual=0 required=1", name);
    end
  endtask

  task automatic run(input string name, input logic [31:0] v, input logic m,
                     input logic [41:0] seg, input logic ovf, input int lat);
    push(seg, ovf, lat);
    @(negedge clk);
    value_in = v;
    hex_mode = m;
    wait_done(name);
  endtask

  // Monitor: each busy fall outside reset is a published result; compare it against the queue head.
  initial begin : monitor
    logic        prev;
    int          lat;
    logic [41:0] seg_rise;
    logic        stable;
    exp_t        e;
    prev = 1'b0;
    lat = 0;
    seg_rise = '1;
    stable = 1'b1;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = 1'b0;
        lat = 0;
      end else begin
        if (busy && !prev) begin
          seg_rise = hex_seg;
          stable = 1'b1;
        end
        if (busy) begin
          lat++;
          if (hex_seg !== seg_rise) stable = 1'b0;
        end
        if (prev && !busy) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result actual=%h required=none", hex_seg);
          end else begin
            e = sb.pop_front();
            chk("hex_seg", 64'(hex_seg), 64'(e.seg));
            chk("overflow", 64'(overflow), 64'(e.ovf));
            chk("valid", 64'(valid), 64'd1);
            chk("busy_edges", 64'(lat), 64'(e.lat));
            chk("seg_stable_while_busy", 64'(stable), 64'd1);
          end
          done_cnt++;
          lat = 0;
        end
        prev = busy;
      end
    end
  end

  initial begin
    reset    = 1'b1;
    value_in = 32'd0;
    hex_mode = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_seg", 64'(hex_seg), {22'd0, {42{1'b1}}});
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_valid", 64'(valid), 64'd0);
    chk("reset_overflow", 64'(overflow), 64'd0);

    push(mk(LZ, LZ, LZ, LZ, LZ, 7'h40), 1'b0, 33);
    reset = 1'b0;
    wait_done("zero_after_reset");

    run("dec_123456", 32'd123456, 1'b0, mk(7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02), 1'b0, 33);
    run("dec_1000000", 32'd1000000, 1'b0, {6{7'h3F}}, 1'b1, 33);
    run("dec_999999", 32'd999999, 1'b0, {6{7'h10}}, 1'b0, 33);
    run("hex_abcdef", 32'h00ABCDEF, 1'b1, mk(7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E), 1'b0, 1);
    run("hex_ovf", 32'h01ABCDEF, 1'b1, {6{7'h3F}}, 1'b1, 1);

    // Value changes mid-conversion: old value finishes, then the new one converts unprompted.
    push(mk(LZ, LZ, LZ, LZ, LZ, 7'h12), 1'b0, 33);
    push(mk(LZ, LZ, LZ, LZ, 7'h19, 7'h24), 1'b0, 33);
    @(negedge clk);
    value_in = 32'd5;
    hex_mode = 1'b0;
    wait_busy("dec_5");
    repeat (9) @(posedge clk);
    @(negedge clk);
    value_in = 32'd42;
    wait_done("dec_5_then_42");

    // Reset in the middle of converting 777.
    @(negedge clk);
    value_in = 32'd777;
    wait_busy("dec_777");
    repeat (14) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midreset_seg", 64'(hex_seg), {22'd0, {42{1'b1}}});
    chk("midreset_busy", 64'(busy), 64'd0);
    chk("midreset_valid", 64'(valid), 64'd0);
    chk("midreset_overflow", 64'(overflow), 64'd0);
    @(negedge clk);
    @(negedge clk);
    push(mk(LZ, LZ, LZ, 7'h78, 7'h78, 7'h78), 1'b0, 33);
    reset = 1'b0;
    wait_done("dec_777_after_reset");

    repeat (40) @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    chk("result_count", 64'(done_cnt), 64'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_display_driver.md
Name: hex_display_driver

Overview:
Consumes the 32-bit out_port word of the HEX output PIO and drives the board's active-low seven-segment displays. Converts the word to decimal using a sequential double-dabble (shift-add-3) engine, or shows it as raw hexadecimal nibbles. It then registers the segment patterns for DIGITS displays. It sits between the Avalon PIO and the HEX pins; it has no bus interface.

Parameters:
DIGITS, 6, number of seven-segment displays driven; legal range 1..8

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
value_in  input  32  unsigned value from the PIO out_port
hex_mode  input  1  0 = decimal display, 1 = hexadecimal display
hex_seg  output  7*DIGITS  segment patterns, active-low; digit d is at [7d+6:7d], with bit order g..a (bit 6 = g, bit 0 = a); digit 0 is rightmost
busy  output  1  conversion in progress
valid  output  1  hex_seg holds at least one completed conversion since reset
overflow  output  1  value not representable in DIGITS digits in the current mode

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high. All state resets on reset rising; release is synchronous to clk.
- Reset values: hex_seg = all 1s (blank, 0x7F per digit); busy=0; valid=0; overflow=0; state=IDLE; shadow registers=0; force flag=1.
- Shadow registers hold the captured value_in and hex_mode.
- States: IDLE, CONVERT, DONE.
- IDLE → capture: at edge E0, IDLE captures if (value_in != shadow value) OR (hex_mode != shadow mode) OR force.
  - On capture: load both shadows; clear force; busy<=1.
  - If hex_mode=0: load a 72-bit shift register = {40'b0, value_in}; clear the iteration counter; go to CONVERT.
  - If hex_mode=1: go directly to DONE.
- CONVERT, edges E1..E32, one iteration per edge:
  - Each of the 10 BCD nibbles in bits [71:32] that is >= 5 gets +3.
  - Then the whole register shifts left by 1.
  - After the 32nd iteration, go to DONE.
  - The counter is 6 bits. No early exit.
- DONE, one edge: register hex_seg and overflow; valid<=1; busy<=0; go to IDLE.
  - Decimal latency: outputs change at E33.
  - Hex latency: outputs change at E1.
  - The next capture can occur no earlier than the following edge.
- Decimal overflow: set when any BCD digit at index >= DIGITS is nonzero. In that case every digit shows dash 0x3F.
- Hex overflow: set when value_in has any nonzero nibble at index >= DIGITS (nibble index d covers bits [4d+3:4d]). In that case every digit shows 0x3F. When DIGITS=8, hex overflow is always 0.
- Encoding (active-low, g..a):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
  - blank=7F
- Change during CONVERT is ignored until IDLE. The captured conversion completes with its old value. The new value then differs from the shadow and triggers a fresh conversion with no external action.
- hex_seg and overflow are stable between DONE updates. There are no glitches during CONVERT.
- Reset mid-conversion: the conversion is abandoned and outputs return to reset values. force=1 guarantees reconversion of the current value_in after release, even if value_in=0.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: in decimal mode without overflow, digits above the most significant nonzero digit show blank 0x7F. Value 0 shows a single 0x40 in digit 0 with all other digits blank. Hex mode and overflow display are unaffected.
- Undefined: all DIGITS digits are always shown, including leading zeros.

Test Plan:
- Reset, value_in=0, hex_mode=0 → blank all digits during reset. After release: busy high for 33 edges, then all six digits = 0x40, valid=1, overflow=0.
- value_in=123456, hex_mode=0 → digits 5..0 = 79,24,30,19,12,02. busy falls exactly 33 edges after the capture edge. With LEADING_ZERO_BLANK_EN, the result is identical.
- value_in=1000000, hex_mode=0 → overflow=1 and all digits = 3F. value_in=999999 → overflow=0 and all digits = 10.
- hex_mode=1, value_in=0x00ABCDEF → digits 5..0 = 08,03,46,21,06,0E, updated at E1 after capture. value_in=0x01ABCDEF → overflow=1 and all 3F.
- value_in 5→42 at E10 of a conversion → first result shows 5 (digit0=12), then a second conversion starts automatically and shows 42 (digit1=19, digit0=24). Without the macro, higher digits = 40. With LEADING_ZERO_BLANK_EN, higher digits = 7F.
- Assert reset at E15 of converting 777 → outputs return to blank, busy=0, valid=0. After release, the full conversion shows 777 (digits 2..0 = 78,78,78).
